// File: rtl/rv32_pkg.sv
// rv32_pkg: shared RV32 execute-stage types and helpers.
//   rv32_alu_op_t  - ALU/M-extension operation codes from decode
//   muldiv_state_t - sequencer FSM states for rv32_muldiv_seq
//   MULDIV_ITERS   - iterations of the shift-add / restoring-divide core
//   is_muldiv_op / is_mul_op / is_div_op - operation class helpers
package rv32_pkg;
    localparam int XLEN         = 32;
    localparam int MULDIV_ITERS = 32;

    typedef enum logic [4:0] {
        ALU_OP_ADD, ALU_OP_SUB, ALU_OP_SLL, ALU_OP_SLT, ALU_OP_SLTU,
        ALU_OP_XOR, ALU_OP_SRL, ALU_OP_SRA, ALU_OP_OR, ALU_OP_AND,
        ALU_OP_MUL, ALU_OP_MULH, ALU_OP_MULHSU, ALU_OP_MULHU,
        ALU_OP_DIV, ALU_OP_DIVU, ALU_OP_REM, ALU_OP_REMU
    } rv32_alu_op_t;

    typedef enum logic [1:0] {IDLE, CALC, DONE} muldiv_state_t;

    function automatic logic is_muldiv_op(input rv32_alu_op_t op);
        return (op >= ALU_OP_MUL) && (op <= ALU_OP_REMU);
    endfunction

    function automatic logic is_mul_op(input rv32_alu_op_t op);
        return (op >= ALU_OP_MUL) && (op <= ALU_OP_MULHU);
    endfunction

    function automatic logic is_div_op(input rv32_alu_op_t op);
        return (op >= ALU_OP_DIV) && (op <= ALU_OP_REMU);
    endfunction
endpackage

// File: rtl/rv32_div_step.sv
// rv32_div_step: one combinational restoring-division step.
//   i_rem     - partial remainder (always < divisor)
//   i_bit     - next dividend bit shifted in
//   i_divisor - divisor magnitude
//   o_rem     - next partial remainder
//   o_q_bit   - quotient bit produced by this step
module rv32_div_step
    import rv32_pkg::*;
(
    input  logic [XLEN-1:0] i_rem,
    input  logic            i_bit,
    input  logic [XLEN-1:0] i_divisor,
    output logic [XLEN-1:0] o_rem,
    output logic            o_q_bit
);
    logic [XLEN:0]   w_shift;
    logic [XLEN-1:0] w_diff;
    logic            w_ge;

    assign w_shift = {i_rem, i_bit};
    // When the trial subtraction succeeds the true difference is below the
    // divisor, so the low XLEN bits hold it exactly.
    assign w_diff  = w_shift[XLEN-1:0] - i_divisor;
    assign w_ge    = (w_shift >= {1'b0, i_divisor});

    assign o_q_bit = w_ge;
    assign o_rem   = w_ge ? w_diff : w_shift[XLEN-1:0];
endmodule

// File: rtl/rv32_muldiv_seq.sv
// rv32_muldiv_seq: multi-cycle RV32M multiply/divide sequencer.
//   clk, rst_n              - clock, synchronous active-low reset
//   req_valid/req_ready     - request handshake (ready only in IDLE, no flush)
//   req_op/rs1/rs2/rd       - operation, operands, destination register
//   flush                   - aborts the operation in flight, no response
//   resp_valid/resp_ready   - response handshake
//   resp_data/resp_rd       - result and echoed destination register
//   busy                    - sequencer not idle
// Optional: RV32_MULDIV_FAST_MUL_EN makes all multiplies single-cycle.
//
// state | meaning
// IDLE  | waiting for a request
// CALC  | one shift-add or restoring-divide iteration per cycle
// DONE  | result held until consumed
module rv32_muldiv_seq
    import rv32_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  rv32_alu_op_t    req_op,
    input  logic [XLEN-1:0] req_rs1,
    input  logic [XLEN-1:0] req_rs2,
    input  logic [4:0]      req_rd,
    input  logic            flush,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_data,
    output logic [4:0]      resp_rd,
    output logic            busy
);
    localparam logic [4:0] LAST_ITER = 5'(MULDIV_ITERS - 1);

    muldiv_state_t     r_state, w_next;
    logic [4:0]        r_cnt;
    rv32_alu_op_t      r_op;
    logic [4:0]        r_rd;
    logic [2*XLEN-1:0] r_acc;
    logic [XLEN-1:0]   r_b;
    logic              r_neg_p;
    logic              r_neg_r;
    logic [XLEN-1:0]   r_res;

    logic              w_req_ready, w_accept;
    logic              w_s1_signed, w_s2_signed, w_n1, w_n2;
    logic [XLEN-1:0]   w_mag1, w_mag2;
    logic              w_div_zero, w_div_ovf, w_fast;
    logic [XLEN-1:0]   w_fast_res;
    logic [XLEN-1:0]   w_div_rem;
    logic              w_div_q;
    logic [XLEN:0]     w_mul_sum;
    logic [2*XLEN-1:0] w_step, w_prod_fix;
    logic [XLEN-1:0]   w_quo_fix, w_rem_fix, w_fix_res;

    assign w_req_ready = (r_state == IDLE) && !flush && rst_n;
    assign w_accept    = req_valid && w_req_ready;

    // Signed operands are carried as magnitudes; the sign is restored at the end.
    assign w_s1_signed = (req_op == ALU_OP_MUL) || (req_op == ALU_OP_MULH) ||
                         (req_op == ALU_OP_MULHSU) || (req_op == ALU_OP_DIV) ||
                         (req_op == ALU_OP_REM);
    assign w_s2_signed = (req_op == ALU_OP_MUL) || (req_op == ALU_OP_MULH) ||
                         (req_op == ALU_OP_DIV) || (req_op == ALU_OP_REM);
    assign w_n1   = w_s1_signed && req_rs1[XLEN-1];
    assign w_n2   = w_s2_signed && req_rs2[XLEN-1];
    assign w_mag1 = w_n1 ? -req_rs1 : req_rs1;
    assign w_mag2 = w_n2 ? -req_rs2 : req_rs2;

    assign w_div_zero = is_div_op(req_op) && (req_rs2 == '0);
    assign w_div_ovf  = ((req_op == ALU_OP_DIV) || (req_op == ALU_OP_REM)) &&
                        (req_rs1 == 32'h8000_0000) && (req_rs2 == 32'hFFFF_FFFF);

`ifdef RV32_MULDIV_FAST_MUL_EN
    logic signed [2*XLEN+1:0] w_fast_prod;
    assign w_fast_prod = $signed({w_s1_signed & req_rs1[XLEN-1], req_rs1}) *
                         $signed({w_s2_signed & req_rs2[XLEN-1], req_rs2});
`endif

    always_comb begin
        w_fast     = 1'b1;
        w_fast_res = '0;
        if (!is_muldiv_op(req_op)) begin
            w_fast_res = '0;
        end else if (w_div_zero) begin
            w_fast_res = ((req_op == ALU_OP_DIV) || (req_op == ALU_OP_DIVU)) ? '1 : req_rs1;
        end else if (w_div_ovf) begin
            w_fast_res = (req_op == ALU_OP_DIV) ? 32'h8000_0000 : '0;
`ifdef RV32_MULDIV_FAST_MUL_EN
        end else if (is_mul_op(req_op)) begin
            w_fast_res = (req_op == ALU_OP_MUL) ? w_fast_prod[XLEN-1:0]
                                                : w_fast_prod[2*XLEN-1:XLEN];
`endif
        end else begin
            w_fast = 1'b0;
        end
    end

    // Divide: r_acc = {partial remainder, dividend shifting out / quotient shifting in}.
    // Multiply: r_acc = {partial product, multiplier shifting out}.
    rv32_div_step u_div_step (
        .i_rem     (r_acc[2*XLEN-1:XLEN]),
        .i_bit     (r_acc[XLEN-1]),
        .i_divisor (r_b),
        .o_rem     (w_div_rem),
        .o_q_bit   (w_div_q)
    );

    assign w_mul_sum = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_b} : '0);
    assign w_step    = is_div_op(r_op) ? {w_div_rem, r_acc[XLEN-2:0], w_div_q}
                                       : {w_mul_sum, r_acc[XLEN-1:1]};

    // Sign correction applied to the final iteration's result on the way into DONE.
    assign w_prod_fix = r_neg_p ? -w_step : w_step;
    assign w_quo_fix  = r_neg_p ? -w_step[XLEN-1:0] : w_step[XLEN-1:0];
    assign w_rem_fix  = r_neg_r ? -w_step[2*XLEN-1:XLEN] : w_step[2*XLEN-1:XLEN];

    always_comb begin
        w_fix_res = w_rem_fix;
        case (r_op)
            ALU_OP_MUL:                              w_fix_res = w_prod_fix[XLEN-1:0];
            ALU_OP_MULH, ALU_OP_MULHSU, ALU_OP_MULHU: w_fix_res = w_prod_fix[2*XLEN-1:XLEN];
            ALU_OP_DIV, ALU_OP_DIVU:                 w_fix_res = w_quo_fix;
            default:                                 w_fix_res = w_rem_fix;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        req_ready  = w_req_ready;
        resp_valid = 1'b0;
        busy       = (r_state != IDLE);
        case (r_state)
            IDLE: if (w_accept) w_next = w_fast ? DONE : CALC;
            CALC: if (r_cnt == LAST_ITER) w_next = DONE;
            DONE: begin
                resp_valid = 1'b1;
                if (resp_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
        if (flush) w_next = IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_op    <= ALU_OP_ADD;
            r_rd    <= '0;
            r_acc   <= '0;
            r_b     <= '0;
            r_neg_p <= 1'b0;
            r_neg_r <= 1'b0;
            r_res   <= '0;
        end else if (w_accept) begin
            r_op    <= req_op;
            r_rd    <= req_rd;
            r_cnt   <= '0;
            r_neg_p <= w_n1 ^ w_n2;
            r_neg_r <= w_n1;
            if (is_div_op(req_op)) begin
                r_acc <= {{XLEN{1'b0}}, w_mag1};
                r_b   <= w_mag2;
            end else begin
                r_acc <= {{XLEN{1'b0}}, w_mag2};
                r_b   <= w_mag1;
            end
            if (w_fast) r_res <= w_fast_res;
        end else if ((r_state == CALC) && !flush) begin
            r_acc <= w_step;
            r_cnt <= r_cnt + 5'd1;
            if (r_cnt == LAST_ITER) r_res <= w_fix_res;
        end
    end

    assign resp_data = r_res;
    assign resp_rd   = r_rd;
endmodule

// File: tb/tb_rv32_muldiv_seq.sv
// tb_rv32_muldiv_seq: self-checking bench for rv32_muldiv_seq.
// Honours RV32_MULDIV_FAST_MUL_EN for the expected multiply latency.
module tb_rv32_muldiv_seq;
    import rv32_pkg::*;

`ifdef RV32_MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 0;
`else
    localparam int MUL_LAT = 32;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req_valid = 1'b0;
    logic         flush = 1'b0;
    logic         resp_ready = 1'b0;
    rv32_alu_op_t req_op = ALU_OP_ADD;
    logic [31:0]  req_rs1 = '0;
    logic [31:0]  req_rs2 = '0;
    logic [4:0]   req_rd = '0;
    logic         req_ready, resp_valid, busy;
    logic [31:0]  resp_data;
    logic [4:0]   resp_rd;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rv32_muldiv_seq dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_rs1    (req_rs1),
        .req_rs2    (req_rs2),
        .req_rd     (req_rd),
        .flush      (flush),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_rd    (resp_rd),
        .busy       (busy)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference results straight from RV32M arithmetic.
    function automatic logic [31:0] model(input rv32_alu_op_t op, input logic [31:0] a,
                                          input logic [31:0] b);
        logic signed [63:0] sa, sb, sub;
        logic [63:0] ua, ub, p;
        sa  = {{32{a[31]}}, a};
        sb  = {{32{b[31]}}, b};
        ua  = {32'b0, a};
        ub  = {32'b0, b};
        sub = $signed(ub);
        p   = '0;
        case (op)
            ALU_OP_MUL:    begin p = sa * sb;  return p[31:0];  end
            ALU_OP_MULH:   begin p = sa * sb;  return p[63:32]; end
            ALU_OP_MULHSU: begin p = sa * sub; return p[63:32]; end
            ALU_OP_MULHU:  begin p = ua * ub;  return p[63:32]; end
            ALU_OP_DIV: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return $signed(a) / $signed(b);
            end
            ALU_OP_REM: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return $signed(a) % $signed(b);
            end
            ALU_OP_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            ALU_OP_REMU: return (b == 0) ? a : a % b;
            default:     return 32'h0;
        endcase
    endfunction

    // Edges after the accept edge until resp_valid is seen.
    function automatic int exp_lat(input rv32_alu_op_t op, input logic [31:0] a,
                                   input logic [31:0] b);
        if (op < ALU_OP_MUL || op > ALU_OP_REMU) return 0;
        if (op >= ALU_OP_DIV) begin
            if (b == 0) return 0;
            if ((op == ALU_OP_DIV || op == ALU_OP_REM) &&
                a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
            return 32;
        end
        return MUL_LAT;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // Transaction-level monitor: one outstanding op with an expected result and latency.
    bit          pend = 0, started = 0, acc_q = 0, hs_q = 0, flush_q = 0, rst_q = 0;
    int          n = 0, e_lat = 0, s_lat = 0;
    logic [31:0] e_data = '0, s_data = '0;
    logic [4:0]  e_rd = '0, s_rd = '0;

    always @(negedge clk) begin
        bit rst_applied;
        rst_applied = rst_q;
        if (rst_q) begin
            pend = 0;
            started = 1;
        end else if (flush_q || hs_q) begin
            pend = 0;
        end else if (acc_q) begin
            pend = 1;
            n = 0;
            e_data = s_data;
            e_rd = s_rd;
            e_lat = s_lat;
        end else if (pend) begin
            n++;
        end

        if (!rst_n) begin
            chk("mon_rst_req_ready", req_ready, 0);
            if (rst_applied) begin
                chk("mon_rst_resp_valid", resp_valid, 0);
                chk("mon_rst_busy", busy, 0);
                chk("mon_rst_resp_data", resp_data, 0);
                chk("mon_rst_resp_rd", resp_rd, 0);
            end
        end else if (started) begin
            chk("mon_busy", busy, pend);
            chk("mon_req_ready", req_ready, !pend && !flush);
            chk("mon_resp_valid", resp_valid, pend && (n >= e_lat));
            if (resp_valid && pend) begin
                chk("mon_resp_data", resp_data, e_data);
                chk("mon_resp_rd", resp_rd, e_rd);
            end
        end

        rst_q   = !rst_n;
        flush_q = flush;
        hs_q    = resp_valid && resp_ready;
        acc_q   = req_valid && req_ready;
        if (acc_q) begin
            s_data = model(req_op, req_rs1, req_rs2);
            s_rd   = req_rd;
            s_lat  = exp_lat(req_op, req_rs1, req_rs2);
        end
    end

    task automatic run_op(input rv32_alu_op_t op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input int rr_pct,
                          output logic [31:0] got, output logic [4:0] got_rd, output int lat);
        int i;
        got = '0;
        got_rd = '0;
        lat = -1;
        @(posedge clk); #1;
        req_valid = 1; req_op = op; req_rs1 = a; req_rs2 = b; req_rd = rd;
        i = 0;
        @(negedge clk);
        while (!req_ready && i < 200) begin
            @(negedge clk);
            i++;
        end
        if (!req_ready) begin
            checks++; errors++;
            $display("FAIL accept_timeout: req_ready got 0 expected 1");
            req_valid = 0;
            return;
        end
        @(posedge clk); #1;
        req_valid = 0;
        resp_ready = ($urandom_range(0, 99) < rr_pct);
        i = 0;
        while (i < 200) begin
            @(negedge clk);
            if (resp_valid && lat < 0) lat = i;
            if (resp_valid && resp_ready) break;
            @(posedge clk); #1;
            resp_ready = ($urandom_range(0, 99) < rr_pct);
            i++;
        end
        if (i >= 200) begin
            checks++; errors++;
            $display("FAIL resp_timeout: resp_valid got 0 expected 1");
        end else begin
            got = resp_data;
            got_rd = resp_rd;
        end
        @(posedge clk); #1;
        resp_ready = 0;
    endtask

    task automatic dir(input string name, input rv32_alu_op_t op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd,
                       input logic [31:0] exp, input int explat);
        logic [31:0] got;
        logic [4:0]  grd;
        int          lat;
        run_op(op, a, b, rd, 100, got, grd, lat);
        chk(name, got, exp);
        chk({name, "_rd"}, grd, rd);
        if (explat >= 0) chk({name, "_lat"}, lat, explat);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0]  got, a, b;
        logic [4:0]   grd, rd;
        int           lat, i, vcount;
        rv32_alu_op_t op;

        chk("pin_divu", model(ALU_OP_DIVU, 100, 7), 14);
        chk("pin_rem", model(ALU_OP_REM, 32'hFFFF_FFF9, 2), 32'hFFFF_FFFF);
        chk("pin_mulhsu", model(ALU_OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFF);
        chk("pin_mulhu", model(ALU_OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFE);
        chk("pin_mul", model(ALU_OP_MUL, 3, 32'hFFFF_FFFC), 32'hFFFF_FFF4);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_resp_data", resp_data, 0);
        chk("rst_resp_rd", resp_rd, 0);
        @(posedge clk); #1 rst_n = 1;
        @(negedge clk);
        chk("rel_req_ready", req_ready, 1);

        dir("divu_100_7", ALU_OP_DIVU, 100, 7, 5'd10, 14, 32);
        dir("remu_100_7", ALU_OP_REMU, 100, 7, 5'd10, 2, 32);
        dir("div_m7_2", ALU_OP_DIV, 32'hFFFF_FFF9, 2, 5'd11, 32'hFFFF_FFFD, 32);
        dir("rem_m7_2", ALU_OP_REM, 32'hFFFF_FFF9, 2, 5'd12, 32'hFFFF_FFFF, 32);
        dir("div_ovf", ALU_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'h8000_0000, 0);
        dir("div_5_0", ALU_OP_DIV, 5, 0, 5'd14, 32'hFFFF_FFFF, 0);
        dir("remu_5_0", ALU_OP_REMU, 5, 0, 5'd15, 5, 0);
        dir("mulh_min", ALU_OP_MULH, 32'h8000_0000, 32'h8000_0000, 5'd16, 32'h4000_0000, MUL_LAT);
        dir("mulhsu_ff", ALU_OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd17, 32'hFFFF_FFFF, MUL_LAT);
        dir("mulhu_ff", ALU_OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd18, 32'hFFFF_FFFE, MUL_LAT);
        dir("mul_3_m4", ALU_OP_MUL, 3, 32'hFFFF_FFFC, 5'd19, 32'hFFFF_FFF4, MUL_LAT);
        dir("non_m_add", ALU_OP_ADD, 7, 9, 5'd20, 0, 0);

        // Consumer stalls for five cycles in DONE.
        @(posedge clk); #1;
        req_valid = 1; req_op = ALU_OP_DIVU; req_rs1 = 100; req_rs2 = 7; req_rd = 5'd3;
        resp_ready = 0;
        @(negedge clk);
        chk("stall_req_ready_idle", req_ready, 1);
        @(posedge clk); #1 req_valid = 0;
        i = 0;
        @(negedge clk);
        while (!resp_valid && i < 100) begin
            @(negedge clk);
            i++;
        end
        chk("stall_valid_seen", resp_valid, 1);
        repeat (5) begin
            @(negedge clk);
            chk("stall_valid", resp_valid, 1);
            chk("stall_data", resp_data, 14);
            chk("stall_req_ready", req_ready, 0);
        end
        @(posedge clk); #1 resp_ready = 1;
        @(negedge clk);
        chk("stall_req_ready_hs", req_ready, 0);
        @(posedge clk); #1 resp_ready = 0;
        @(negedge clk);
        chk("stall_req_ready_after", req_ready, 1);
        chk("stall_valid_after", resp_valid, 0);

        // Flush at CALC iteration 10.
        @(posedge clk); #1;
        req_valid = 1; req_op = ALU_OP_DIVU; req_rs1 = 1000; req_rs2 = 3; req_rd = 5'd7;
        resp_ready = 1;
        @(negedge clk);
        @(posedge clk); #1 req_valid = 0;
        repeat (9) @(posedge clk);
        #1 flush = 1;
        @(posedge clk); #1 flush = 0;
        @(negedge clk);
        chk("flush_busy", busy, 0);
        chk("flush_valid", resp_valid, 0);
        vcount = 0;
        repeat (40) begin
            @(negedge clk);
            if (resp_valid) vcount++;
        end
        chk("flush_no_resp", vcount, 0);
        resp_ready = 0;
        dir("flush_then_divu", ALU_OP_DIVU, 9, 3, 5'd8, 3, 32);

        // Flush beats a request in IDLE.
        @(posedge clk); #1;
        flush = 1; req_valid = 1; req_op = ALU_OP_DIVU; req_rs1 = 9; req_rs2 = 3;
        @(negedge clk);
        chk("flush_idle_req_ready", req_ready, 0);
        @(posedge clk); #1 flush = 0; req_valid = 0;
        @(negedge clk);
        chk("flush_idle_busy", busy, 0);

        // Flush beats resp_ready in DONE: response dropped.
        @(posedge clk); #1;
        req_valid = 1; req_op = ALU_OP_DIV; req_rs1 = 5; req_rs2 = 0; req_rd = 5'd9;
        @(negedge clk);
        @(posedge clk); #1 req_valid = 0;
        @(negedge clk);
        chk("flush_done_valid", resp_valid, 1);
        @(posedge clk); #1 flush = 1; resp_ready = 1;
        @(posedge clk); #1 flush = 0; resp_ready = 0;
        @(negedge clk);
        chk("flush_done_dropped", resp_valid, 0);
        chk("flush_done_busy", busy, 0);

        // Reset mid-CALC.
        @(posedge clk); #1;
        req_valid = 1; req_op = ALU_OP_DIV; req_rs1 = 12345; req_rs2 = 32'hFFFF_FFF9; req_rd = 5'd21;
        @(negedge clk);
        @(posedge clk); #1 req_valid = 0;
        repeat (5) @(posedge clk);
        #1 rst_n = 0;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_busy", busy, 0);
        chk("midrst_valid", resp_valid, 0);
        chk("midrst_data", resp_data, 0);
        chk("midrst_rd", resp_rd, 0);
        chk("midrst_req_ready", req_ready, 0);
        @(posedge clk); #1 rst_n = 1;
        @(negedge clk);
        chk("midrst_rel_req_ready", req_ready, 1);

        // Randomized operations against the reference model.
        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(0, 9) < 8) op = rv32_alu_op_t'($urandom_range(10, 17));
            else                          op = rv32_alu_op_t'($urandom_range(0, 17));
            a  = pick();
            b  = pick();
            rd = 5'($urandom_range(0, 31));
            run_op(op, a, b, rd, 60, got, grd, lat);
            chk("rand_data", got, model(op, a, b));
            chk("rand_rd", grd, rd);
            chk("rand_lat", lat, exp_lat(op, a, b));
        end

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
